// File: rtl/axis_1553_pkg.sv
// axis_1553_pkg: shared sync codes, tuser indices, line rate and FSM encoding for the 1553 decoder
package axis_1553_pkg;
  localparam logic [2:0] SYNC_CMD = 3'b100;
  localparam logic [2:0] SYNC_DATA = 3'b010;
  localparam int TU_OVR = 2;
  localparam int TU_MAN = 1;
  localparam int TU_PAR = 0;
  localparam int BASE_RATE = 1000000;
  typedef enum logic [1:0] {IDLE, SYNC_CHK, BITS, DONE} state_t;
  function automatic int clogb2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_1553_rx_sampler.sv
// axis_1553_rx_sampler: two-flop synchronizer on the line plus a sample-enable divider
module axis_1553_rx_sampler
  import axis_1553_pkg::*;
#(
  parameter int div = 1
) (
  input  logic       aclk,
  input  logic       arst,
  input  logic [1:0] diff,
  output logic [1:0] diff_s,
  output logic       sample_en
);
  localparam int CW = clogb2(div);
  logic [1:0] s0;
  logic [CW-1:0] cnt;
  assign sample_en = cnt == CW'(div - 1);
  always_ff @(posedge aclk) begin
    if (arst) begin
      s0 <= '0;
      diff_s <= '0;
      cnt <= '0;
    end else begin
      s0 <= diff;
      diff_s <= s0;
      cnt <= sample_en ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/axis_1553_decoder.sv
// axis_1553_decoder: 1553 Manchester receiver presenting decoded words on an AXI-Stream master.
// Optional error counter (err_count/err_clr) enabled by AXIS_1553_DECODER_ERR_CNT_EN.
module axis_1553_decoder
  import axis_1553_pkg::*;
#(
  parameter int clock_speed = 16000000,
  parameter int sample_rate = 16000000,
  parameter int sync_tol = 2
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        parity_set,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
`ifdef AXIS_1553_DECODER_ERR_CNT_EN
  ,
  input  logic        err_clr,
  output logic [7:0]  err_count
`endif
);
  localparam int SPB = sample_rate / BASE_RATE;
  localparam int HALF = SPB / 2;
  localparam int Q1 = SPB / 4;
  localparam int Q3 = 3 * SPB / 4;
  localparam int SYNC = 3 * SPB / 2;
  localparam int RW = clogb2(SYNC + sync_tol + 2);
  localparam int CW = clogb2(SPB);
  state_t state, state_d;
  logic [1:0] diff_s;
  logic se, hi, vld, cur, stype, tail, h1, h1v, man, ovr;
  logic in_win, chg, bit_err, last, wrap, load, perr;
  logic [RW-1:0] run;
  logic [CW-1:0] cnt;
  logic [4:0] bidx;
  logic [16:0] sh;
  axis_1553_rx_sampler #(.div(clock_speed / sample_rate)) u_sampler (
    .aclk(aclk),
    .arst(arst),
    .diff(diff),
    .diff_s(diff_s),
    .sample_en(se)
  );
  assign hi = diff_s == 2'b01;
  assign vld = ^diff_s;
  assign in_win = run >= RW'(SYNC - sync_tol) && run <= RW'(SYNC + sync_tol);
  assign chg = vld && run != '0 && hi != cur;
  assign bit_err = !vld || !h1v || h1 == hi;
  assign wrap = cnt == CW'(SPB - 1);
  assign last = cnt == CW'(Q3) && bidx == 5'd17;
  assign load = !m_axis_tvalid || m_axis_tready;
  assign perr = sh[0] ^ (^sh[16:1]) ^ parity_set;
  always_ff @(posedge aclk) begin
    if (arst) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: state_d = (se && !tail && chg && in_win) ? SYNC_CHK : IDLE;
      SYNC_CHK: state_d = !(se && cnt == CW'(HALF)) ? SYNC_CHK : (vld && hi == cur) ? BITS : IDLE;
      BITS: state_d = (se && last) ? DONE : BITS;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (arst) begin
      run <= '0;
      cnt <= '0;
      bidx <= '0;
      sh <= '0;
      cur <= 1'b0;
      stype <= 1'b0;
      tail <= 1'b0;
      h1 <= 1'b0;
      h1v <= 1'b0;
      man <= 1'b0;
      ovr <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (se) begin
        unique case (state)
          // tail masks the rest of the parity window so a back-to-back sync run is not lengthened
          IDLE, DONE:
            if (tail) begin
              run <= '0;
              cnt <= wrap ? '0 : cnt + 1'b1;
              tail <= !wrap;
            end else if (!vld) run <= '0;
            else if (run == '0 || hi == cur) begin
              run <= &run ? run : run + 1'b1;
              cur <= hi;
            end else if (in_win) begin
              run <= '0;
              stype <= !cur;
              cur <= hi;
              cnt <= CW'(1);
            end else begin
              run <= RW'(1);
              cur <= hi;
            end
          // the sync's second half acts as window -1 so bit windows line up with cnt
          SYNC_CHK: begin
            cnt <= cnt == CW'(HALF) ? CW'(1) : cnt + 1'b1;
            bidx <= '0;
            man <= 1'b0;
          end
          BITS: begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) bidx <= bidx + 1'b1;
            if (cnt == CW'(Q1)) begin
              h1 <= hi;
              h1v <= vld;
            end
            if (cnt == CW'(Q3) && bidx != '0) begin
              sh <= {sh[15:0], hi};
              man <= man | bit_err;
            end
            if (last) tail <= 1'b1;
          end
        endcase
      end
      if (state == DONE) begin
        if (load) begin
          m_axis_tdata <= sh[16:1];
          m_axis_tuser <= {stype ? SYNC_CMD : SYNC_DATA, 2'b00, ovr, man, perr};
          m_axis_tvalid <= 1'b1;
          ovr <= 1'b0;
        end else ovr <= 1'b1;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
    end
  end
`ifdef AXIS_1553_DECODER_ERR_CNT_EN
  logic inc;
  assign inc = state == DONE && (!load || man || perr);
  always_ff @(posedge aclk) begin
    if (arst || err_clr) err_count <= '0;
    else if (inc && err_count != 8'hFF) err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_axis_1553_decoder.sv
// tb_axis_1553_decoder: directed Manchester stimulus with a queue scoreboard on the AXI-Stream output
module tb_axis_1553_decoder;
  import axis_1553_pkg::*;
  localparam logic [1:0] HI = 2'b01;
  localparam logic [1:0] LO = 2'b10;
  logic aclk = 1'b0;
  logic arst = 1'b1;
  logic parity_set = 1'b0;
  logic m_axis_tready = 1'b1;
  logic [1:0] diff = 2'b00;
  logic [15:0] m_axis_tdata;
  logic [7:0] m_axis_tuser;
  logic m_axis_tvalid;
`ifdef AXIS_1553_DECODER_ERR_CNT_EN
  logic err_clr = 1'b0;
  logic [7:0] err_count;
`endif
  typedef struct {
    logic [15:0] d;
    logic [7:0] u;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int xfers = 0;
  int x0;
  logic stall = 1'b0;
  logic [15:0] hd;
  logic [7:0] hu;
  always #5 aclk = ~aclk;
  axis_1553_decoder dut (
    .aclk(aclk),
    .arst(arst),
    .parity_set(parity_set),
    .diff(diff),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_1553_DECODER_ERR_CNT_EN
    ,
    .err_clr(err_clr),
    .err_count(err_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_word(input logic [15:0] d, input logic [7:0] u);
    exp_t e;
    e.d = d;
    e.u = u;
    q.push_back(e);
  endtask
  always @(negedge aclk) begin
    if (arst) stall = 1'b0;
    else begin
      if (stall) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, hd);
        check("hold_tuser", m_axis_tuser, hu);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        xfers++;
        if (q.size() == 0) check("extra_word", q.size(), 1);
        else begin
          exp_t e;
          e = q.pop_front();
          check("tdata", m_axis_tdata, e.d);
          check("tuser", m_axis_tuser, e.u);
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      hd = m_axis_tdata;
      hu = m_axis_tuser;
    end
  end
  task automatic put(input logic [1:0] v, input int n);
    repeat (n) begin
      diff = v;
      @(posedge aclk);
      #1;
    end
  endtask
  // force_k: bit window driven high throughout; rst_k: window whose first sample pulses arst
  task automatic send(input logic [15:0] d, input logic cmd, input logic bad, input int force_k, input int rst_k);
    logic [16:0] w;
    logic b;
    w = {d, ^d ^ parity_set ^ bad};
    put(cmd ? LO : HI, 24);
    put(cmd ? HI : LO, 24);
    for (int k = 0; k < 17; k++) begin
      b = w[16-k];
      for (int s = 0; s < 16; s++) begin
        diff = (k == force_k) ? HI : (((s < 8) ? !b : b) ? HI : LO);
        arst = (k == rst_k && s == 0);
        @(posedge aclk);
        #1;
        if (arst) begin
          arst = 1'b0;
          check("rst_tvalid", m_axis_tvalid, 0);
          check("rst_tdata", m_axis_tdata, 0);
          check("rst_tuser", m_axis_tuser, 0);
        end
      end
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_left", q.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_tuser", m_axis_tuser, 0);
    check("reset_state", dut.state, IDLE);
    arst = 1'b0;
    put(2'b00, 10);
    x0 = xfers;
    expect_word(16'hA5C3, 8'h80);
    send(16'hA5C3, 1'b1, 1'b0, -1, -1);
    drain();
    repeat (20) @(posedge aclk);
    #1;
    check("t1_pulses", xfers - x0, 1);
    check("t1_tvalid_low", m_axis_tvalid, 0);
    parity_set = 1'b1;
    expect_word(16'h0001, 8'h41);
    send(16'h0001, 1'b0, 1'b1, -1, -1);
    expect_word(16'h1234 | 16'h0020, 8'h42);
    send(16'h1234, 1'b0, 1'b0, 10, -1);
    drain();
    put(2'b00, 10);
    parity_set = 1'b0;
    m_axis_tready = 1'b0;
    expect_word(16'h1111, 8'h40);
    send(16'h1111, 1'b0, 1'b0, -1, -1);
    send(16'h2222, 1'b0, 1'b0, -1, -1);
    put(2'b00, 10);
    check("t4_held_valid", m_axis_tvalid, 1);
    check("t4_held_data", m_axis_tdata, 16'h1111);
    m_axis_tready = 1'b1;
    put(2'b00, 4);
    expect_word(16'h3333, 8'h44);
    send(16'h3333, 1'b0, 1'b0, -1, -1);
    drain();
    put(2'b00, 10);
    x0 = xfers;
    put(LO, 16);
    put(HI, 16);
    put(2'b00, 10);
    check("t5_state", dut.state, IDLE);
    check("t5_no_word", xfers - x0, 0);
    check("t5_tvalid", m_axis_tvalid, 0);
    expect_word(16'h5AF0, 8'h80);
    send(16'h5AF0, 1'b1, 1'b0, -1, -1);
    drain();
    put(2'b00, 10);
    m_axis_tready = 1'b0;
    x0 = xfers;
    send(16'h0F0F, 1'b0, 1'b0, -1, -1);
    put(2'b00, 10);
    check("t6_held_valid", m_axis_tvalid, 1);
    send(16'hBEEF, 1'b1, 1'b0, -1, 8);
    put(2'b00, 20);
    check("t6_no_word_valid", m_axis_tvalid, 0);
    check("t6_state", dut.state, IDLE);
    m_axis_tready = 1'b1;
    expect_word(16'hFFFF, 8'h80);
    send(16'hFFFF, 1'b1, 1'b0, -1, -1);
    drain();
    check("t6_xfers", xfers - x0, 1);
    repeat (20) @(posedge aclk);
    #1;
    check("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
